enc_rr_arbiter: RTL
===================

// Module: enc_rr_arbiter
// PURPOSE
//  Round-robin scheduler for the shared 8-line encoder resource. Up to 8 requesters
//  raise req; the block grants exactly one at a time and holds the grant until the
//  grantee signals done, withdraws, or exceeds a hold budget. It drives the one-hot
//  enc_y* select and the matching 3-bit index, and replaces an uncontrolled encoder
//  input with a fair, timed, handshaked access path.
// PARAMETERS
//  NREQ      8   number of requesters (fixed at 8 to match the 3-bit index)
//  IDXW      3   grant index width
//  MAX_HOLD  16  max consecutive grant cycles before forced release (>=2)
// PORTS
//  CLK       in   1     clock, all state on rising edge
//  RST       in   1     asynchronous, active-high reset
//  req       in   8     request vector, bit i = requester i
//  EN_done   in   1     grantee finished; sampled only while RDY_gnt=1
//  gnt       out  8     one-hot grant (drives enc_y select); 0 when idle
//  gnt_idx   out  3     binary index of gnt; 0 when idle
//  RDY_gnt   out  1     grant valid
//  timeout   out  1     1-cycle pulse: previous grant was force-released
// BEHAVIOUR
//  - All outputs registered. On RST (async, immediate): gnt=0, gnt_idx=0, RDY_gnt=0,
//    timeout=0, ptr=0, hold_cnt=0, state=IDLE. Reset mid-grant drops grant at once.
//  - States: IDLE -> GRANT -> RELEASE -> IDLE.
//  - IDLE: if req!=0, pick winner = first set bit searching ptr, ptr+1, ... mod 8
//    (wraps 7->0); next cycle gnt=1<<winner, gnt_idx=winner, RDY_gnt=1, hold_cnt=0,
//    state=GRANT. Latency req->gnt = 1 cycle. req=0 -> stay IDLE. EN_done ignored.
//  - GRANT: hold_cnt increments each cycle (width $clog2(MAX_HOLD+1), no wrap).
//    Release when any of:  EN_done=1;  req[gnt_idx]=0 (withdrawn);
//    hold_cnt==MAX_HOLD-1 (budget spent). On release: next cycle gnt=0, gnt_idx=0,
//    RDY_gnt=0, ptr=(gnt_idx+1) mod 8, state=RELEASE.
//    Grant is therefore high for at most MAX_HOLD cycles.
//  - timeout=1 in the RELEASE cycle only if release was caused solely by budget;
//    EN_done or withdrawal in the same cycle as budget expiry -> timeout=0.
//  - RELEASE: one mandatory dead cycle (gnt=0, no arbitration), then IDLE.
//    Earliest re-grant = 2 cycles after the releasing cycle; same requester may win
//    again only if no other req set (ptr has advanced past it).
//  - req changes during GRANT for non-granted bits have no effect until next IDLE.
//  - Invariant: gnt is 0 or one-hot; gnt==(1<<gnt_idx) whenever RDY_gnt=1.
// TESTING
//  1 RST pulse mid-run, req=8'hFF -> gnt=0, gnt_idx=0, RDY_gnt=0, timeout=0 at once;
//    after release, first grant gnt=8'h01.
//  2 ptr=0, req=8'b1010_0100 at cyc0 -> cyc1 gnt=8'h04, idx=2; EN_done at cyc3 ->
//    cyc4 gnt=0 (RELEASE), cyc5 IDLE, cyc6 gnt=8'h20, idx=5.
//  3 Wrap: after grant to idx5 (ptr=6), req=8'h21 -> next grant idx0, then idx5.
//  4 MAX_HOLD=16, req=8'h08 held, no done -> gnt=8'h08 exactly 16 cycles, then
//    timeout=1 for 1 cycle with gnt=0; re-grant idx3 two cycles later.
//  5 EN_done coincident with hold_cnt==15 -> release, timeout stays 0.
//  6 Grantee idx2 drops req[2] in cycle 3 of grant -> gnt=0 next cycle, timeout=0,
//    ptr=3.

Source files
------------

// File: rtl/enc_rr_arbiter.sv
// Round-robin scheduler for the shared 8-line encoder: one-hot grant plus index,
// held until done, withdrawal or hold-budget expiry, then one dead cycle.
module enc_rr_arbiter #(
  parameter int NREQ     = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req,
  input  logic            EN_done,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            RDY_gnt,
  output logic            timeout
);
  localparam int HCW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDXW-1:0]   gnt_idx_q, gnt_idx_d;
  logic              rdy_q, rdy_d;
  logic              timeout_q, timeout_d;

  logic              found;
  logic [IDXW-1:0]   win_idx;
  logic [IDXW-1:0]   cand;
  logic              rel_done, rel_wd, rel_bud, release_now;

  // Rotating priority search; index arithmetic wraps naturally because NREQ == 2**IDXW.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr_q + IDXW'(i);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign rel_done    = EN_done;
  assign rel_wd      = !req[gnt_idx_q];
  assign rel_bud     = (hold_cnt_q == HCW'(MAX_HOLD - 1));
  assign release_now = (state_q == GRANT) && (rel_done || rel_wd || rel_bud);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      rdy_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      rdy_q      <= rdy_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = GRANT;
      GRANT:   if (release_now) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    rdy_d      = rdy_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = NREQ'(1) << win_idx;
          gnt_idx_d  = win_idx;
          rdy_d      = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d      = '0;
          gnt_idx_d  = '0;
          rdy_d      = 1'b0;
          hold_cnt_d = '0;
          ptr_d      = gnt_idx_q + IDXW'(1);
          // Only a pure budget expiry counts as a forced release.
          timeout_d  = rel_bud && !rel_done && !rel_wd;
        end else if (hold_cnt_q != HCW'(MAX_HOLD)) begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      default: ;
    endcase
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign RDY_gnt = rdy_q;
  assign timeout = timeout_q;
endmodule
